cfg_initiator: RTL
==================

# cfg_initiator

Host-side initiator for the configuration-write handshake served by the control unit. On a `start` pulse it captures a 35-bit config word and a 2-bit key, then runs the protocol: `request` pulse, `password` presentation, `confirm` pulse, wait for `write_en`. It checks the `configout` readback against the captured word and retries a bounded number of times. It sits between the user/test front end and the control unit, driving that unit's `request`/`confirm`/`password`/`configin` inputs and consuming its `write_en`/`configout` outputs.

## Interface
Parameters:
- `WIDTH`, 35: config word width
- `TIMEOUT`, 16: cycles spent in WAIT before an attempt is declared lost (≥2)
- `MAX_ATTEMPTS`, 3: total attempts before FAIL (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `arst` in 1: reset, asynchronous, active-low
- `start` in 1: begin a transaction; sampled only in IDLE
- `cfg_data` in WIDTH: word to write; captured with `start`
- `key` in 2: password to present; captured with `start`
- `write_en` in 1: control unit's write strobe
- `configout` in WIDTH: control unit readback
- `request` out 1: one-cycle request pulse
- `confirm` out 1: one-cycle confirm pulse
- `password` out 2: captured key; held for the whole transaction
- `configin` out WIDTH: captured word; held for the whole transaction
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle success pulse
- `fail` out 1: one-cycle failure pulse
- `dbg_state` out 3: current state encoding

## Operation
States and `dbg_state` encodings: IDLE=0, REQ=1, KEY=2, CONF=3, WAIT=4, VERIFY=5, DONE=6, FAIL=7.
- IDLE: on `start`=1, register `cfg_data` and `key` into capture registers, clear the attempt counter, then go to REQ. `start` in any other state is ignored.
- REQ: `request`=1 for one cycle, then KEY.
- KEY: `password` stable, with no strobes, for one cycle, then CONF.
- CONF: `confirm`=1 for one cycle. Clear the wait counter, then WAIT.
- WAIT:
  - `write_en`=1 → VERIFY.
  - Otherwise increment the wait counter. When it reaches TIMEOUT-1 without `write_en`, end the attempt.
  - If `write_en` arrives on the same cycle the timeout fires, `write_en` wins.
- VERIFY: one cycle. Compare registered `configout` with the captured word. Equal → DONE; unequal → end the attempt.
- End of attempt: increment the attempt counter. If it is below MAX_ATTEMPTS → REQ, reusing the captured word and key; otherwise → FAIL.
- DONE: `done`=1 for one cycle, then IDLE. FAIL: `fail`=1 for one cycle, then IDLE.
- `write_en` outside WAIT is ignored.
- `password`/`configin` keep their last captured values in IDLE until the next accepted `start`.

## Timing
- All outputs are registered. `dbg_state` reflects the current state register.
- Reset (`arst`=0), asynchronous from any state: state=IDLE and all outputs 0 (`request`, `confirm`, `busy`, `done`, `fail`, `password`=0, `configin`=0, `dbg_state`=0). Counters and capture registers also clear.
- Latency, with `start` accepted at edge 0:
  - `request` high in the cycle after edge 0.
  - `confirm` in the third cycle after edge 0.
  - WAIT is entered one cycle later.
- One attempt with no `write_en` occupies REQ+KEY+CONF+TIMEOUT = 19 cycles at defaults.
- Back-to-back: `start` asserted in the cycle following DONE/FAIL is accepted.
- `configout` is sampled one cycle after `write_en`. The control unit must hold `configout` valid from `write_en` through the following cycle.

## Structure
- Shared package `cfg_pkg`:
  - state encoding constants (3-bit)
  - default `WIDTH` (35)
  - default `TIMEOUT`
  - default `MAX_ATTEMPTS`

  These constants are shared with the control unit bench and its model.
- One sub-module, `cfg_timeout_timer`: a clearable up-counter with a `clr`/`en` interface and an `expired` flag at TIMEOUT-1, reset by `arst`.
- FSM, capture registers and attempt counter live in `cfg_initiator`.

## Test plan
- Nominal: `start` with `cfg_data`=35'h0_1234_5678, `key`=2'b10. The model raises `write_en` 3 cycles after `confirm` and echoes the word. Required: one `request` pulse, `password`=2'b10 throughout, `done` pulse, `busy` falls the cycle after DONE, `dbg_state` sequence 0,1,2,3,4,4,4,5,6,0.
- Timeout exhaustion: `write_en` never asserted. Required: exactly 3 `request` pulses, 19 cycles apart. `fail` pulses once after the third WAIT expires, `done` never asserts.
- Mismatch then retry: the first readback returns 35'h0_1234_5679, the second returns the correct word. Required: 2 `request` pulses, then `done`, with no `fail`.
- Simultaneous event: `write_en` first asserted on the 16th WAIT cycle. Required: VERIFY entered, success, no retry.
- Busy protection and reset: pulse `start` with new data during WAIT. Required: ignored, `configin` unchanged. Then drop `arst` mid-WAIT. Required: all outputs 0 and `dbg_state`=0 without waiting for a clock edge; after release, a new `start` runs normally.

Source files
------------

// File: rtl/cfg_pkg.sv
// Constants shared by the configuration-write initiator, the control-unit bench and its model.
package cfg_pkg;

    localparam int unsigned CfgWidth       = 35;
    localparam int unsigned CfgTimeout     = 16;
    localparam int unsigned CfgMaxAttempts = 3;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StReq    = 3'd1,
        StKey    = 3'd2,
        StConf   = 3'd3,
        StWait   = 3'd4,
        StVerify = 3'd5,
        StDone   = 3'd6,
        StFail   = 3'd7
    } cfg_state_e;

endpackage

// File: rtl/cfg_initiator_if.sv
// Initiator <-> control-unit handshake: strobes and captured data out, write strobe and readback in.
interface cfg_initiator_if
    import cfg_pkg::*;
#(
    parameter int unsigned WIDTH = CfgWidth
) ();

    logic             request;
    logic             confirm;
    logic [1:0]       password;
    logic [WIDTH-1:0] configin;
    logic             write_en;
    logic [WIDTH-1:0] configout;

    modport master (
        output request, confirm, password, configin,
        input  write_en, configout
    );

    modport slave (
        input  request, confirm, password, configin,
        output write_en, configout
    );

endinterface

// File: rtl/cfg_timeout_timer.sv
// Clearable up-counter that flags expiry once it has counted TIMEOUT-1 enabled cycles.
module cfg_timeout_timer
    import cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT = CfgTimeout
) (
    input  logic clk,
    input  logic arst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned       CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q, count_d;

    assign expired = (count_q == Last);

    // Saturates at Last so a late enable cannot wrap back into a fresh window.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cfg_initiator.sv
// Host-side initiator: captures a word and key on start, drives request/key/confirm, waits for
// the write strobe, verifies the readback and retries a bounded number of times.
module cfg_initiator
    import cfg_pkg::*;
#(
    parameter int unsigned WIDTH        = CfgWidth,
    parameter int unsigned TIMEOUT      = CfgTimeout,
    parameter int unsigned MAX_ATTEMPTS = CfgMaxAttempts
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [1:0]       key,
    cfg_initiator_if.master  cu,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [2:0]       dbg_state
);

    localparam int unsigned AttW = $clog2(MAX_ATTEMPTS + 1);

    cfg_state_e       state_q, state_d;
    logic [WIDTH-1:0] cfg_q, cfg_d;
    logic [1:0]       key_q, key_d;
    logic [AttW-1:0]  att_q, att_d, att_inc;
    logic [WIDTH-1:0] readback_q;
    logic             request_q, confirm_q, busy_q, done_q, fail_q;
    logic             tmr_clr, tmr_en, tmr_expired, end_attempt;

    cfg_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .arst    (arst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign att_inc = att_q + AttW'(1);

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        key_d       = key_q;
        att_d       = att_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        end_attempt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cfg_d   = cfg_data;
                    key_d   = key;
                    att_d   = '0;
                    state_d = StReq;
                end
            end
            StReq:  state_d = StKey;
            StKey:  state_d = StConf;
            StConf: begin
                tmr_clr = 1'b1;
                state_d = StWait;
            end
            // write_en is checked before expiry so a strobe on the last cycle still counts.
            StWait: begin
                tmr_en = 1'b1;
                if (cu.write_en) begin
                    state_d = StVerify;
                end else if (tmr_expired) begin
                    end_attempt = 1'b1;
                end
            end
            StVerify: begin
                if (readback_q == cfg_q) begin
                    state_d = StDone;
                end else begin
                    end_attempt = 1'b1;
                end
            end
            StDone, StFail: state_d = StIdle;
            default:        state_d = StIdle;
        endcase
        if (end_attempt) begin
            att_d   = att_inc;
            state_d = (att_inc < AttW'(MAX_ATTEMPTS)) ? StReq : StFail;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= StIdle;
            cfg_q      <= '0;
            key_q      <= '0;
            att_q      <= '0;
            readback_q <= '0;
            request_q  <= 1'b0;
            confirm_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            key_q      <= key_d;
            att_q      <= att_d;
            readback_q <= cu.configout;
            request_q  <= (state_d == StReq);
            confirm_q  <= (state_d == StConf);
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
            fail_q     <= (state_d == StFail);
        end
    end

    assign cu.request  = request_q;
    assign cu.confirm  = confirm_q;
    assign cu.password = key_q;
    assign cu.configin = cfg_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign dbg_state   = state_q;

endmodule
